// File: rtl/rv32i_instr_encoder.sv
// rtl/rv32i_instr_encoder.sv - streaming RV32I instruction encoder with 2-entry output FIFO
module rv32i_instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [15:0]       word_count,
    output logic [15:0]       err_count
);

    logic [1:0]        count;
    logic [ADDR_W-1:0] next_addr;
    logic [31:0]       tail_instr;
    logic [ADDR_W-1:0] tail_addr;
    logic              tail_err;
    logic [31:0]       enc_instr;
    logic              enc_err;
    logic              push;
    logic              pop;
    logic              is_bad;
    logic              b_bad;
    logic              j_bad;

    assign in_ready  = (count < 2'd2) && !restart;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Immediate fits when all bits above the field's sign bit match it
    assign is_bad = !((&imm[31:11]) || !(|imm[31:11]));
    assign b_bad  = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
    assign j_bad  = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];

    always_comb begin
        enc_instr = 32'h0000_0013;
        enc_err   = 1'b1;
        case (fmt)
            3'd0: begin
                enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
                enc_err   = 1'b0;
            end
            3'd1: begin
                enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
                enc_err   = is_bad;
            end
            3'd2: begin
                enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc_err   = is_bad;
            end
            3'd3: begin
                enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_err   = b_bad;
            end
            3'd4: begin
                enc_instr = {imm[31:12], rd, opcode};
                enc_err   = (imm[11:0] != 12'd0);
            end
            3'd5: begin
                enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc_err   = j_bad;
            end
            3'd6: begin
                enc_instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                enc_err   = (imm[31:5] != 27'd0);
            end
            default: begin
                enc_instr = 32'h0000_0013;
                enc_err   = 1'b1;
            end
        endcase
    end

    // Head is held in the out_* registers so it keeps its value once the FIFO drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 2'd0;
            next_addr  <= BASE_ADDR;
            out_instr  <= 32'd0;
            out_addr   <= '0;
            out_err    <= 1'b0;
            tail_instr <= 32'd0;
            tail_addr  <= '0;
            tail_err   <= 1'b0;
            word_count <= 16'd0;
            err_count  <= 16'd0;
        end else if (restart) begin
            count      <= 2'd0;
            next_addr  <= BASE_ADDR;
            word_count <= 16'd0;
            err_count  <= 16'd0;
        end else begin
            if (push) begin
                next_addr <= next_addr + ADDR_W'(4);
                if (word_count != 16'hFFFF)
                    word_count <= word_count + 16'd1;
                if (enc_err && (err_count != 16'hFFFF))
                    err_count <= err_count + 16'd1;
            end
            case (count)
                2'd0: begin
                    if (push) begin
                        out_instr <= enc_instr;
                        out_addr  <= next_addr;
                        out_err   <= enc_err;
                        count     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        out_instr <= enc_instr;
                        out_addr  <= next_addr;
                        out_err   <= enc_err;
                    end else if (push) begin
                        tail_instr <= enc_instr;
                        tail_addr  <= next_addr;
                        tail_err   <= enc_err;
                        count      <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        out_instr <= tail_instr;
                        out_addr  <= tail_addr;
                        out_err   <= tail_err;
                        count     <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb/tb_rv32i_instr_encoder.sv - directed table-driven bench for rv32i_instr_encoder
module tb_rv32i_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        restart;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic [15:0] word_count;
    logic [15:0] err_count;

    rv32i_instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .word_count(word_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [12];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        fmt = v.fmt; opcode = v.opcode; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.funct3; funct7 = v.funct7; imm = v.imm;
    endtask

    task automatic send_one(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        in_valid = 1'b1;
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_instr"}, out_instr, v.exp_instr);
        chk({name, "_err"}, 32'(out_err), 32'(v.exp_err));
        chk({name, "_addr"}, out_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        exp_addr = 32'd0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int   acc;
        vec_t v;
        //          fmt   op      rd    rs1   rs2   f3    f7    imm            instr          err
        vecs[0]  = '{3'd1, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'd0, 32'd10,        32'h00A00093, 1'b0};
        vecs[1]  = '{3'd1, 7'h13, 5'd2,  5'd1,  5'd0,  3'd0, 7'd0, -32'sd5,       32'hFFB08113, 1'b0};
        vecs[2]  = '{3'd2, 7'h23, 5'd0,  5'd11, 5'd1,  3'd2, 7'd0, 32'd0,         32'h0015A023, 1'b0};
        vecs[3]  = '{3'd3, 7'h63, 5'd0,  5'd12, 5'd13, 3'd0, 7'd0, 32'd8,         32'h00D60463, 1'b0};
        vecs[4]  = '{3'd5, 7'h6F, 5'd16, 5'd0,  5'd0,  3'd0, 7'd0, 32'd8,         32'h0080086F, 1'b0};
        vecs[5]  = '{3'd4, 7'h37, 5'd19, 5'd0,  5'd0,  3'd0, 7'd0, 32'h12345000,  32'h123459B7, 1'b0};
        vecs[6]  = '{3'd6, 7'h13, 5'd9,  5'd8,  5'd0,  3'd1, 7'd0, 32'd3,         32'h00341493, 1'b0};
        vecs[7]  = '{3'd6, 7'h13, 5'd10, 5'd8,  5'd0,  3'd5, 7'd0, 32'd1,         32'h00145513, 1'b0};
        vecs[8]  = '{3'd7, 7'h33, 5'd3,  5'd4,  5'd5,  3'd7, 7'd0, 32'd0,         32'h00000013, 1'b1};
        vecs[9]  = '{3'd1, 7'h13, 5'd0,  5'd0,  5'd0,  3'd0, 7'd0, 32'd2048,      32'h80000013, 1'b1};
        vecs[10] = '{3'd3, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'd0, 32'd7,         32'h00000363, 1'b1};
        vecs[11] = '{3'd4, 7'h37, 5'd19, 5'd0,  5'd0,  3'd0, 7'd0, 32'h12345001,  32'h123459B7, 1'b1};

        rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(vecs[0]);
        exp_addr = 32'd0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_addr", out_addr, 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_wcnt", 32'(word_count), 32'd0);
        chk("rst_ecnt", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) send_one(vecs[i], $sformatf("vec%0d", i));
        @(negedge clk);
        chk("tbl_valid_drained", 32'(out_valid), 32'd0);
        chk("tbl_hold_instr", out_instr, vecs[8].exp_instr);
        chk("tbl_wcnt", 32'(word_count), 32'd9);
        chk("tbl_ecnt", 32'(err_count), 32'd1);

        // Backpressure: only two words fit while the consumer stalls
        do_restart();
        out_ready = 1'b0;
        acc = 0;
        v = vecs[0];
        v.imm = 32'd0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            v.imm = 32'(c);
            drive(v);
            in_valid = 1'b1;
            if (in_ready) acc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_instr", out_instr, 32'h00000093);
        out_ready = 1'b1;
        chk("bp_head0_addr", out_addr, 32'd0);
        @(negedge clk);
        chk("bp_head1_valid", 32'(out_valid), 32'd1);
        chk("bp_head1_instr", out_instr, 32'h00100093);
        chk("bp_head1_addr", out_addr, 32'd4);
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Push and pop together at count 1: head advances to the new word
        exp_addr = 32'd8;
        @(negedge clk);
        drive(vecs[1]);
        in_valid = 1'b1;
        @(negedge clk);
        chk("pp_first", out_instr, vecs[1].exp_instr);
        chk("pp_ready", 32'(in_ready), 32'd1);
        drive(vecs[2]);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pp_second", out_instr, vecs[2].exp_instr);
        chk("pp_addr", out_addr, 32'd12);
        chk("pp_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("pp_drained", 32'(out_valid), 32'd0);

        // Restart with two words queued
        out_ready = 1'b0;
        drive(vecs[3]);
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        restart = 1'b1;
        chk("rs_queued", 32'(out_valid), 32'd1);
        chk("rs_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        restart = 1'b0;
        in_valid = 1'b0;
        chk("rs_valid", 32'(out_valid), 32'd0);
        chk("rs_wcnt", 32'(word_count), 32'd0);
        chk("rs_ecnt", 32'(err_count), 32'd0);
        out_ready = 1'b1;
        exp_addr = 32'd0;
        send_one(vecs[4], "rs_first");

        // Range errors after a clean restart
        do_restart();
        for (int i = 9; i < 12; i++) send_one(vecs[i], $sformatf("err%0d", i));
        chk("err_ecnt", 32'(err_count), 32'd3);
        chk("err_wcnt", 32'(word_count), 32'd3);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        @(negedge clk);
        drive(vecs[5]);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar_queued", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_instr", out_instr, 32'd0);
        chk("ar_addr", out_addr, 32'd0);
        chk("ar_err", 32'(out_err), 32'd0);
        chk("ar_wcnt", 32'(word_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        exp_addr = 32'd0;
        send_one(vecs[6], "ar_first");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
